// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the 16-bit CPU datapath.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and decodes datapath enables.
module cpu_ctrl_fsm #(
  parameter int         CNT_W   = 16,
  parameter logic [3:0] CMP_OP  = 4'b0101,
  parameter logic [3:0] HALT_OP = 4'b1111
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [15:0]      ir_i,
  input  logic             flag_z_i,
  input  logic             flag_s_i,
  input  logic             flag_v_i,
  input  logic             mem_ack_i,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic             pc_sel_o,
  output logic [3:0]       alu_op_o,
  output logic             alu_src_imm_o,
  output logic             flags_we_o,
  output logic             reg_we_o,
  output logic             wb_sel_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             mem_addr_sel_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] retired_o
);

  // state  | meaning
  // IDLE   | waiting for start
  // FETCH  | instruction read at PC, IR/PC load on ack
  // DECODE | IR settles, halt detection
  // EXEC   | ALU op, branch resolve, or address calc for LD/ST
  // MEM    | data access at ALU result
  // WB     | load data written to regfile
  // HALT   | core stopped until reset
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [1:0] CLS_LD  = 2'b00;
  localparam logic [1:0] CLS_ST  = 2'b01;
  localparam logic [1:0] CLS_BR  = 2'b10;
  localparam logic [1:0] CLS_ALU = 2'b11;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;

  logic [1:0] cls;
  logic [3:0] ir_op;
  logic       is_halt;
  logic       br_taken;
  logic       unused_ir_bits;

  assign cls            = ir_i[15:14];
  assign ir_op          = ir_i[7:4];
  assign is_halt        = (cls == CLS_ALU) && (ir_op == HALT_OP);
  assign unused_ir_bits = ^{ir_i[10:8], ir_i[3:0]};

  always_comb begin
    br_taken = 1'b0;
    case (ir_i[13:11])
      3'b000:  br_taken = flag_z_i;
      3'b001:  br_taken = flag_s_i ^ flag_v_i;
      3'b010:  br_taken = flag_z_i | (flag_s_i ^ flag_v_i);
      3'b011:  br_taken = ~flag_z_i;
      3'b111:  br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_FETCH;
      S_FETCH:  if (mem_ack_i) state_d = S_DECODE;
      S_DECODE: state_d = is_halt ? S_HALT : S_EXEC;
      S_EXEC: begin
        if ((cls == CLS_LD) || (cls == CLS_ST)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_MEM: begin
        if (mem_ack_i) begin
          if (cls == CLS_ST) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
    retired_d = retired_q + CNT_W'(retire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // IR/PC load in FETCH follows the ack so both land on the completing edge.
  always_comb begin
    ir_we_o        = 1'b0;
    pc_we_o        = 1'b0;
    pc_sel_o       = 1'b0;
    alu_op_o       = 4'b0000;
    alu_src_imm_o  = 1'b0;
    flags_we_o     = 1'b0;
    reg_we_o       = 1'b0;
    wb_sel_o       = 1'b0;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_sel_o = 1'b0;
    halted_o       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_o = 1'b1;
        ir_we_o   = mem_ack_i;
        pc_we_o   = mem_ack_i;
      end
      S_EXEC: begin
        case (cls)
          CLS_ALU: begin
            alu_op_o   = ir_op;
            flags_we_o = 1'b1;
            reg_we_o   = (ir_op != CMP_OP);
          end
          CLS_BR: begin
            alu_op_o      = 4'b0101;
            alu_src_imm_o = 1'b1;
            pc_we_o       = br_taken;
            pc_sel_o      = br_taken;
          end
          default: begin
            alu_op_o      = 4'b0000;
            alu_src_imm_o = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        mem_req_o      = 1'b1;
        mem_addr_sel_o = 1'b1;
        mem_we_o       = (cls == CLS_ST);
      end
      S_WB: begin
        reg_we_o = 1'b1;
        wb_sel_o = 1'b1;
      end
      S_HALT:  halted_o = 1'b1;
      default: ;
    endcase
  end

  assign retired_o = retired_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm: directed instruction vectors, reset corners, and a random
// program checked cycle by cycle against an instruction-level trace model.
module tb_cpu_ctrl_fsm;
  localparam int         CW  = 4;
  localparam logic [3:0] CMP = 4'b0101;
  localparam logic [3:0] HLT = 4'b1111;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mem_ack = 1'b0;
  logic flag_z = 1'b0, flag_s = 1'b0, flag_v = 1'b0;
  logic [15:0] ir = 16'h0000;
  logic ir_we, pc_we, pc_sel, alu_src_imm, flags_we, reg_we, wb_sel;
  logic mem_req, mem_we, mem_addr_sel, halted;
  logic [3:0] alu_op;
  logic [CW-1:0] retired;
  logic [15:0] obs_v;

  int n_cmp = 0, n_bad = 0;
  logic [CW-1:0] exp_ret;

  always #5 clk = ~clk;

  cpu_ctrl_fsm #(.CNT_W(CW), .CMP_OP(CMP), .HALT_OP(HLT)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .ir_i(ir),
    .flag_z_i(flag_z), .flag_s_i(flag_s), .flag_v_i(flag_v), .mem_ack_i(mem_ack),
    .ir_we_o(ir_we), .pc_we_o(pc_we), .pc_sel_o(pc_sel), .alu_op_o(alu_op),
    .alu_src_imm_o(alu_src_imm), .flags_we_o(flags_we), .reg_we_o(reg_we),
    .wb_sel_o(wb_sel), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_sel_o(mem_addr_sel), .halted_o(halted), .retired_o(retired)
  );

  assign obs_v = {ir_we, pc_we, pc_sel, alu_op, alu_src_imm, flags_we, reg_we,
                  wb_sel, mem_req, mem_we, mem_addr_sel, halted};

  function automatic logic [15:0] pk(input logic irw, pcw, pcs, input logic [3:0] op,
                                     input logic imm, fwe, rwe, wbs, req, we, asel, hlt);
    return {irw, pcw, pcs, op, imm, fwe, rwe, wbs, req, we, asel, hlt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_ret = '0;
  endtask

  task automatic start_core();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  typedef struct {
    logic [15:0] ir;
    logic z, s, v;
    int fw, mw, cyc;
    logic [3:0] op;
    logic tk, rwe, fwe, mwe, wbs, hlt;
    int inc;
  } vec_t;

  function automatic vec_t mkv(input logic [15:0] i, input logic z, s, v, input int fw, mw, cyc,
                               input logic [3:0] op, input logic tk, rwe, fwe, mwe, wbs, hlt,
                               input int inc);
    vec_t r;
    r.ir = i; r.z = z; r.s = s; r.v = v; r.fw = fw; r.mw = mw; r.cyc = cyc; r.op = op;
    r.tk = tk; r.rwe = rwe; r.fwe = fwe; r.mwe = mwe; r.wbs = wbs; r.hlt = hlt; r.inc = inc;
    return r;
  endfunction

  // Starts in the first FETCH cycle; returns at the first cycle of the next FETCH (or HALT).
  task automatic run_vec(input vec_t v, input int idx);
    int cyc = 0, wcnt = 0, req_cnt = 0, exp_req;
    logic fetched = 1'b0, fetch_ok = 1'b0, ack, hl = 1'b0;
    logic [3:0] op_acc = 4'h0;
    logic pw = 1'b0, ps = 1'b0, rw = 1'b0, fe = 1'b0, mwr = 1'b0, wb = 1'b0;
    ir = v.ir; flag_z = v.z; flag_s = v.s; flag_v = v.v;
    while (cyc < 20) begin
      if (fetched && mem_req && !mem_addr_sel) break;
      if (halted) begin hl = 1'b1; break; end
      ack = 1'b0;
      if (mem_req) begin
        if (wcnt == (mem_addr_sel ? v.mw : v.fw)) begin ack = 1'b1; wcnt = 0; end
        else wcnt++;
      end
      mem_ack = ack;
      @(negedge clk);
      if (fetched) begin
        op_acc |= alu_op; pw |= pc_we; ps |= pc_sel; rw |= reg_we; fe |= flags_we;
        mwr |= mem_we & mem_req; wb |= wb_sel;
        if (mem_req) req_cnt++;
      end else if (ack) begin
        fetch_ok = ir_we & pc_we & ~pc_sel;
      end
      if (ack && !mem_addr_sel) fetched = 1'b1;
      cyc++;
      @(posedge clk);
      #1 mem_ack = 1'b0;
    end
    exp_ret = exp_ret + CW'(v.inc);
    exp_req = (v.ir[15] == 1'b0) ? v.mw + 1 : 0;
    check($sformatf("v%0d_fetch_load", idx), fetch_ok, 1);
    check($sformatf("v%0d_cycles", idx), cyc, v.cyc);
    check($sformatf("v%0d_alu_op", idx), op_acc, v.op);
    check($sformatf("v%0d_pc_we", idx), pw, v.tk);
    check($sformatf("v%0d_pc_sel", idx), ps, v.tk);
    check($sformatf("v%0d_reg_we", idx), rw, v.rwe);
    check($sformatf("v%0d_flags_we", idx), fe, v.fwe);
    check($sformatf("v%0d_mem_we", idx), mwr, v.mwe);
    check($sformatf("v%0d_wb_sel", idx), wb, v.wbs);
    check($sformatf("v%0d_halted", idx), hl, v.hlt);
    check($sformatf("v%0d_mem_req_cycles", idx), req_cnt, exp_req);
    check($sformatf("v%0d_retired", idx), retired, exp_ret);
  endtask

  typedef struct {
    logic        ack;
    logic        ld;
    logic [15:0] e;
    logic [CW-1:0] r;
  } step_t;

  function automatic step_t mks(input logic ack, ld, input logic [15:0] e, input logic [CW-1:0] r);
    step_t s;
    s.ack = ack; s.ld = ld; s.e = e; s.r = r;
    return s;
  endfunction

  function automatic logic cond_met(input logic [2:0] c, input logic z, s, v);
    case (c)
      3'd0:    return z;
      3'd1:    return s != v;
      3'd2:    return z || (s != v);
      3'd3:    return !z;
      3'd7:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  vec_t vt[16];
  step_t tr[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = mkv(16'hC020, 0, 0, 0, 0, 0, 3,  4'h2, 0, 1, 1, 0, 0, 0, 1);
    vt[1]  = mkv(16'hC050, 0, 0, 0, 0, 0, 3,  4'h5, 0, 0, 1, 0, 0, 0, 1);
    vt[2]  = mkv(16'h0005, 0, 0, 0, 3, 3, 11, 4'h0, 0, 1, 0, 0, 1, 0, 1);
    vt[3]  = mkv(16'h4003, 0, 0, 0, 0, 0, 4,  4'h0, 0, 0, 0, 1, 0, 0, 1);
    vt[4]  = mkv(16'h8004, 1, 0, 0, 0, 0, 3,  4'h5, 1, 0, 0, 0, 0, 0, 1);
    vt[5]  = mkv(16'h8004, 0, 0, 0, 0, 0, 3,  4'h5, 0, 0, 0, 0, 0, 0, 1);
    vt[6]  = mkv(16'hB804, 0, 0, 0, 0, 0, 3,  4'h5, 1, 0, 0, 0, 0, 0, 1);
    vt[7]  = mkv(16'hA004, 1, 1, 1, 0, 0, 3,  4'h5, 0, 0, 0, 0, 0, 0, 1);
    vt[8]  = mkv(16'h8804, 0, 1, 0, 0, 0, 3,  4'h5, 1, 0, 0, 0, 0, 0, 1);
    vt[9]  = mkv(16'h8804, 0, 1, 1, 0, 0, 3,  4'h5, 0, 0, 0, 0, 0, 0, 1);
    vt[10] = mkv(16'h9004, 0, 0, 1, 0, 0, 3,  4'h5, 1, 0, 0, 0, 0, 0, 1);
    vt[11] = mkv(16'h9804, 1, 0, 0, 0, 0, 3,  4'h5, 0, 0, 0, 0, 0, 0, 1);
    vt[12] = mkv(16'hC0A0, 0, 0, 0, 1, 0, 4,  4'hA, 0, 1, 1, 0, 0, 0, 1);
    vt[13] = mkv(16'h0005, 0, 0, 0, 0, 0, 5,  4'h0, 0, 1, 0, 0, 1, 0, 1);
    vt[14] = mkv(16'h4003, 0, 0, 0, 2, 1, 7,  4'h0, 0, 0, 0, 1, 0, 0, 1);
    vt[15] = mkv(16'hC0F0, 0, 0, 0, 0, 0, 2,  4'h0, 0, 0, 0, 0, 0, 1, 0);

    // Reset and idle
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("idle_outputs_c%0d", i), obs_v, 16'h0000);
      check($sformatf("idle_retired_c%0d", i), retired, 0);
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    @(negedge clk);
    check("idle_no_req_with_start", mem_req, 0);
    @(posedge clk);
    #1 start = 1'b0;
    check("start_fetch_req", {mem_req, mem_addr_sel, mem_we}, 3'b100);

    for (int i = 0; i < 16; i++) run_vec(vt[i], i);

    // Halted core ignores acks and freezes the counter
    for (int i = 0; i < 5; i++) begin
      mem_ack = 1'(i % 2);
      @(negedge clk);
      check($sformatf("halt_hold_c%0d", i), obs_v, pk(0,0,0,4'h0,0,0,0,0,0,0,0,1));
      check($sformatf("halt_retired_c%0d", i), retired, exp_ret);
      @(posedge clk);
      #1 mem_ack = 1'b0;
    end

    // Reset in the middle of a store's MEM phase
    do_reset();
    start_core();
    ir = 16'h4003;
    mem_ack = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 mem_ack = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("pre_rst_mem_phase", {mem_req, mem_addr_sel, mem_we}, 3'b111);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req_drop", mem_req, 0);
    check("async_rst_outputs", obs_v, 16'h0000);
    check("async_rst_retired", retired, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("idle_after_rst_c%0d", i), obs_v, 16'h0000);
    end

    // Random program against the instruction-level trace model
    do_reset();
    start_core();
    for (int n = 0; n < 300; n++) begin
      logic [15:0] ins;
      logic z, s, v, tk, st;
      logic [3:0] op;
      int fw, mw;
      ins = 16'($urandom);
      if (ins[15:14] == 2'b11 && ins[7:4] == HLT) ins[7:4] = 4'h3;
      z = 1'($urandom); s = 1'($urandom); v = 1'($urandom);
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      op = ins[7:4];
      tr.delete();
      for (int k = 0; k < fw; k++) tr.push_back(mks(0, 0, pk(0,0,0,4'h0,0,0,0,0,1,0,0,0), exp_ret));
      tr.push_back(mks(1, 0, pk(1,1,0,4'h0,0,0,0,0,1,0,0,0), exp_ret));
      tr.push_back(mks(1'($urandom), 1, 16'h0000, exp_ret));
      case (ins[15:14])
        2'b11: begin
          tr.push_back(mks(1'($urandom), 0, pk(0,0,0,op,0,1,op != CMP,0,0,0,0,0), exp_ret));
          exp_ret++;
        end
        2'b10: begin
          tk = cond_met(ins[13:11], z, s, v);
          tr.push_back(mks(1'($urandom), 0, pk(0,tk,tk,4'h5,1,0,0,0,0,0,0,0), exp_ret));
          exp_ret++;
        end
        default: begin
          st = ins[14];
          tr.push_back(mks(1'($urandom), 0, pk(0,0,0,4'h0,1,0,0,0,0,0,0,0), exp_ret));
          for (int k = 0; k < mw; k++) tr.push_back(mks(0, 0, pk(0,0,0,4'h0,0,0,0,0,1,st,1,0), exp_ret));
          tr.push_back(mks(1, 0, pk(0,0,0,4'h0,0,0,0,0,1,st,1,0), exp_ret));
          if (st) begin
            exp_ret++;
          end else begin
            tr.push_back(mks(1'($urandom), 0, pk(0,0,0,4'h0,0,0,1,1,0,0,0,0), exp_ret));
            exp_ret++;
          end
        end
      endcase
      foreach (tr[k]) begin
        if (tr[k].ld) begin
          ir = ins; flag_z = z; flag_s = s; flag_v = v;
        end
        mem_ack = tr[k].ack;
        @(negedge clk);
        check($sformatf("rnd%0d_s%0d_outputs ir=%h", n, k, ins), obs_v, tr[k].e);
        check($sformatf("rnd%0d_s%0d_retired", n, k), retired, tr[k].r);
        @(posedge clk);
        #1 mem_ack = 1'b0;
      end
    end
    @(negedge clk);
    check("rnd_final_retired", retired, exp_ret);
    check("rnd_final_in_fetch", {mem_req, mem_addr_sel}, 2'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
